upload_io_reader: RTL and testbench

UPLOAD_IO_READER -- requirements
Module: upload_io_reader

---
 rtl/upload_io_reader.sv | 183 ++++++++++++++++++
 tb/tb_upload_io_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upload_io_reader.sv
// Word reader over the ioctl upload port: gathers 32/DW beats from byte memory
// into one 32-bit response, with a session (upload_start/upload_done) gating memory access.
module upload_io_reader #(
    parameter logic [3:0] MASK  = 4'd0,
    parameter int         AW    = 27,
    parameter int         DW    = 8,
    parameter int         DELAY = 4
) (
    input  logic          clk_memory,
    input  logic          reset,
    input  logic          upload_start_i,
    input  logic [15:0]   upload_id_i,
    input  logic          upload_done_i,
    input  logic          bridge_endian_little_i,
    input  logic          req_valid_i,
    input  logic [31:0]   req_addr_i,
    output logic          req_ready_o,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_data_o,
    output logic          ioctl_upload_o,
    output logic [15:0]   ioctl_index_o,
    output logic          ioctl_rd_o,
    output logic [AW-1:0] ioctl_addr_o,
    input  logic [DW-1:0] ioctl_din_i,
    output logic          upload_busy_o,
    output logic [15:0]   upload_cycles_left_o,
    output logic [15:0]   words_read_o,
    output logic [1:0]    state_dbg_o
);

    localparam int            N        = 32 / DW;
    localparam logic [AW-1:0] STEP     = AW'(DW / 8);
    localparam logic [7:0]    DLY      = 8'(DELAY);
    localparam logic [15:0]   LOAD_MEM = 16'(N * (DELAY + 1));
    localparam logic [1:0]    LAST     = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic [7:0]    dly_q, dly_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   rsp_q, rsp_d;
    logic          little_q, little_d;
    logic [15:0]   left_q, left_d;
    logic          upload_q, upload_d;
    logic          pend_q, pend_d;
    logic [15:0]   index_q, index_d;
    logic [15:0]   words_q, words_d;
    logic          sample;
    logic [31:0]   word_out;
    logic [31:0]   addr_unused;

    assign addr_unused = req_addr_i;

    // req_valid/req_ready: a request transfers in a cycle where both are high;
    // req_valid while req_ready is low is dropped, never held pending.
    assign req_ready_o          = (state_q == IDLE) && !reset;
    assign rsp_valid_o          = (state_q == RESP);
    assign ioctl_rd_o           = (state_q == STROBE);
    assign upload_busy_o        = (state_q != IDLE);
    assign ioctl_addr_o         = addr_q;
    assign ioctl_upload_o       = upload_q;
    assign ioctl_index_o        = index_q;
    assign upload_cycles_left_o = left_q;
    assign words_read_o         = words_q;
    assign state_dbg_o          = state_q;

    // acc_q holds bytes in address order (lowest address in the top byte).
    assign word_out   = little_q ? {acc_q[7:0], acc_q[15:8], acc_q[23:16], acc_q[31:24]} : acc_q;
    assign rsp_data_o = (state_q == RESP) ? word_out : rsp_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        dly_d    = dly_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        rsp_d    = rsp_q;
        little_d = little_q;
        left_d   = left_q;
        upload_d = upload_q;
        pend_d   = pend_q;
        index_d  = index_q;
        words_d  = words_q;
        sample   = 1'b0;

        if (state_q != IDLE && left_q != 16'd0) left_d = left_q - 16'd1;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = {req_addr_i[AW-1:2], 2'b00};
                    little_d = bridge_endian_little_i;
                    acc_d    = 32'd0;
                    beat_d   = 2'd0;
                    if (upload_q && req_addr_i[31:28] == MASK) begin
                        state_d = STROBE;
                        left_d  = LOAD_MEM;
                    end else begin
                        state_d = RESP;
                        left_d  = 16'd0;
                    end
                end
            end
            STROBE: begin
                state_d = WAIT;
                dly_d   = DLY;
            end
            WAIT: begin
                if (dly_q == 8'd1) sample = 1'b1;
                else               dly_d  = dly_q - 8'd1;
            end
            RESP: begin
                state_d = IDLE;
                rsp_d   = word_out;
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            acc_d = {acc_q[31-DW:0], ioctl_din_i};
            if (beat_q == LAST) begin
                state_d = RESP;
            end else begin
                state_d = STROBE;
                beat_d  = beat_q + 2'd1;
                addr_d  = addr_q + STEP;
            end
        end

        // A close request during a word is parked until that word's response.
        if (upload_done_i) begin
            if (state_q == IDLE) upload_d = 1'b0;
            else                 pend_d   = 1'b1;
        end
        if (state_q == RESP) begin
            if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
            if (pend_q || upload_done_i) begin
                upload_d = 1'b0;
                pend_d   = 1'b0;
            end
        end
        if (upload_start_i) begin
            upload_d = 1'b1;
            index_d  = upload_id_i;
            words_d  = 16'd0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            dly_q    <= 8'd0;
            addr_q   <= '0;
            acc_q    <= 32'd0;
            rsp_q    <= 32'd0;
            little_q <= 1'b0;
            left_q   <= 16'd0;
            upload_q <= 1'b0;
            pend_q   <= 1'b0;
            index_q  <= 16'd0;
            words_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            dly_q    <= dly_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            rsp_q    <= rsp_d;
            little_q <= little_d;
            left_q   <= left_d;
            upload_q <= upload_d;
            pend_q   <= pend_d;
            index_q  <= index_d;
            words_q  <= words_d;
        end
    end

endmodule

// File: tb/tb_upload_io_reader.sv
// Bench for upload_io_reader: timing-formula model checked every cycle on the
// byte-wide instance, plus directed literal checks on a halfword-wide instance.
module tb_upload_io_reader;
  localparam int AW = 27;
  localparam int D  = 4;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // byte-wide instance (A)
  logic        up_start_a = 0, up_done_a = 0, little_a = 0, req_valid_a = 0;
  logic [15:0] up_id_a = 0;
  logic [31:0] req_addr_a = 0;
  logic        req_ready_a, rsp_valid_a, upload_a, rd_a, busy_a;
  logic [31:0] rsp_data_a;
  logic [15:0] index_a, left_a, words_a;
  logic [AW-1:0] addr_a;
  logic [7:0]  din_a;
  logic [1:0]  dbg_a;
  logic [7:0]  mem_a [0:255];
  assign din_a = mem_a[addr_a[7:0]];

  upload_io_reader #(.MASK(4'd0), .AW(AW), .DW(8), .DELAY(D)) dut_a (
    .clk_memory(clk), .reset(reset),
    .upload_start_i(up_start_a), .upload_id_i(up_id_a), .upload_done_i(up_done_a),
    .bridge_endian_little_i(little_a), .req_valid_i(req_valid_a), .req_addr_i(req_addr_a),
    .req_ready_o(req_ready_a), .rsp_valid_o(rsp_valid_a), .rsp_data_o(rsp_data_a),
    .ioctl_upload_o(upload_a), .ioctl_index_o(index_a), .ioctl_rd_o(rd_a),
    .ioctl_addr_o(addr_a), .ioctl_din_i(din_a), .upload_busy_o(busy_a),
    .upload_cycles_left_o(left_a), .words_read_o(words_a), .state_dbg_o(dbg_a));

  // halfword-wide instance (B)
  logic        up_start_b = 0, req_valid_b = 0;
  logic [31:0] req_addr_b = 0;
  logic        req_ready_b, rsp_valid_b, upload_b, rd_b, busy_b;
  logic [31:0] rsp_data_b;
  logic [15:0] index_b, left_b, words_b;
  logic [AW-1:0] addr_b;
  logic [15:0] din_b;
  logic [1:0]  dbg_b;
  assign din_b = (addr_b == 27'h40) ? 16'hAABB : (addr_b == 27'h42) ? 16'hCCDD : 16'h0000;

  upload_io_reader #(.MASK(4'd0), .AW(AW), .DW(16), .DELAY(1)) dut_b (
    .clk_memory(clk), .reset(reset),
    .upload_start_i(up_start_b), .upload_id_i(16'h0009), .upload_done_i(1'b0),
    .bridge_endian_little_i(1'b0), .req_valid_i(req_valid_b), .req_addr_i(req_addr_b),
    .req_ready_o(req_ready_b), .rsp_valid_o(rsp_valid_b), .rsp_data_o(rsp_data_b),
    .ioctl_upload_o(upload_b), .ioctl_index_o(index_b), .ioctl_rd_o(rd_b),
    .ioctl_addr_o(addr_b), .ioctl_din_i(din_b), .upload_busy_o(busy_b),
    .upload_cycles_left_o(left_b), .words_read_o(words_b), .state_dbg_o(dbg_b));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model of instance A ----------------
  logic          m_busy = 0, m_upload = 0, m_pend = 0, m_bypass = 0;
  logic [15:0]   m_index = 0, m_words = 0;
  logic [31:0]   m_word = 0, m_hold = 0;
  logic [AW-1:0] m_base = 0;
  int            m_t = 0, m_l = 0;

  always @(posedge clk) begin
    logic busy_c, upl_c;
    logic [7:0] b [4];
    if (reset) begin
      m_busy = 0; m_upload = 0; m_pend = 0; m_index = 0; m_words = 0; m_hold = 0;
    end else begin
      busy_c = m_busy;
      upl_c  = m_upload;
      if (busy_c && (cyc - m_t) == m_l) begin
        m_hold = m_word;
        m_busy = 0;
        if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
        if (m_pend || up_done_a) begin m_upload = 0; m_pend = 0; end
      end else if (up_done_a) begin
        if (busy_c) m_pend = 1; else m_upload = 0;
      end
      if (up_start_a) begin m_upload = 1; m_index = up_id_a; m_words = 0; m_pend = 0; end
      if (!busy_c && req_valid_a) begin
        m_t      = cyc;
        m_base   = {req_addr_a[AW-1:2], 2'b00};
        m_bypass = !upl_c || (req_addr_a[31:28] != 4'd0);
        m_l      = m_bypass ? 1 : 1 + NB * (D + 1);
        for (int j = 0; j < 4; j++) b[j] = mem_a[8'(m_base[7:0] + 8'(j))];
        if (m_bypass)      m_word = 32'd0;
        else if (little_a) m_word = {b[3], b[2], b[1], b[0]};
        else               m_word = {b[0], b[1], b[2], b[3]};
        m_busy = 1;
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare for instance A ----------------
  always @(negedge clk) begin
    int  rel;
    logic mem_phase, resp;
    if (reset) begin
      chk("rst_req_ready", req_ready_a, 0);
      chk("rst_rsp_valid", rsp_valid_a, 0);
      chk("rst_rsp_data", rsp_data_a, 0);
      chk("rst_upload", upload_a, 0);
      chk("rst_index", index_a, 0);
      chk("rst_rd", rd_a, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_left", left_a, 0);
      chk("rst_words", words_a, 0);
    end else begin
      rel       = cyc - m_t;
      resp      = m_busy && rel == m_l;
      mem_phase = m_busy && !m_bypass && rel < m_l;
      chk("req_ready", req_ready_a, !m_busy);
      chk("upload_busy", busy_a, m_busy);
      chk("rsp_valid", rsp_valid_a, resp);
      chk("rsp_data", rsp_data_a, resp ? m_word : m_hold);
      chk("ioctl_rd", rd_a, mem_phase && ((rel - 1) % (D + 1)) == 0);
      if (mem_phase) chk("ioctl_addr", addr_a, 27'(m_base + 27'((rel - 1) / (D + 1))));
      chk("cycles_left", left_a, m_busy ? 32'(m_l - rel) : 0);
      chk("ioctl_upload", upload_a, m_upload);
      chk("ioctl_index", index_a, m_index);
      chk("words_read", words_a, m_words);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [15:0] id);
    up_start_a = 1; up_id_a = id;
    tick(1);
    up_start_a = 0;
  endtask

  task automatic req_a(input logic [31:0] addr, input logic little, output int t);
    req_valid_a = 1; req_addr_a = addr; little_a = little; t = cyc;
    tick(1);
    req_valid_a = 0;
  endtask

  task automatic wait_rsp_a(output int t_rsp, output logic [31:0] data);
    t_rsp = -1; data = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid_a) begin t_rsp = cyc; data = rsp_data_a; break; end
    end
    if (t_rsp < 0) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int t, tr;
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i * 7 + 3);
    mem_a[8'h10] = 8'h11; mem_a[8'h11] = 8'h22; mem_a[8'h12] = 8'h33; mem_a[8'h13] = 8'h44;
    mem_a[8'h30] = 8'hA1; mem_a[8'h31] = 8'hB2; mem_a[8'h32] = 8'hC3; mem_a[8'h33] = 8'hD4;

    tick(3);
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", req_ready_a, 1);
    tick(1);

    // big-endian word
    start_a(16'h0003);
    req_a(32'h0000_0010, 0, t);
    wait_rsp_a(tr, d);
    chk("be_latency", 32'(tr - t), 21);
    chk("be_data", d, 32'h1122_3344);
    tick(1);

    // little-endian word
    req_a(32'h0000_0010, 1, t);
    wait_rsp_a(tr, d);
    chk("le_data", d, 32'h4433_2211);
    tick(1);
    @(negedge clk);
    chk("words_after_two", words_a, 2);
    chk("index_latched", index_a, 16'h0003);
    tick(1);

    // masked-out address answers immediately with zero
    req_a(32'h1000_0010, 0, t);
    wait_rsp_a(tr, d);
    chk("mask_latency", 32'(tr - t), 1);
    chk("mask_data", d, 0);
    tick(1);

    // unaligned address, little-endian, other bytes
    req_a(32'h0000_0105, 1, t);
    wait_rsp_a(tr, d);
    chk("unaligned_data", d, {mem_a[7], mem_a[6], mem_a[5], mem_a[4]});
    tick(1);

    // ignored second request and deferred session close
    req_a(32'h0000_0020, 0, t);
    tick(2);
    req_valid_a = 1; req_addr_a = 32'h0000_0030;
    tick(1);
    req_valid_a = 0;
    tick(1);
    up_done_a = 1;
    tick(1);
    up_done_a = 0;
    wait_rsp_a(tr, d);
    chk("deferred_latency", 32'(tr - t), 21);
    tick(1);
    @(negedge clk);
    chk("upload_closed", upload_a, 0);
    chk("no_queued_req", busy_a, 0);
    tick(3);

    // reset mid-word, then a fresh word
    start_a(16'h0005);
    req_a(32'h0000_0030, 0, t);
    tick(7);
    reset = 1;
    @(negedge clk);
    chk("abort_rd", rd_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_rsp_valid", rsp_valid_a, 0);
    tick(2);
    reset = 0;
    tick(1);
    start_a(16'h0007);
    req_a(32'h0000_0030, 0, t);
    wait_rsp_a(tr, d);
    chk("fresh_latency", 32'(tr - t), 21);
    chk("fresh_data", d, 32'hA1B2_C3D4);
    tick(2);

    // halfword instance, DELAY=1
    up_start_b = 1;
    tick(1);
    up_start_b = 0;
    req_valid_b = 1; req_addr_b = 32'h0000_0040; t = cyc;
    tick(1);
    req_valid_b = 0;
    for (int rel = 1; rel <= 5; rel++) begin
      @(negedge clk);
      chk("b_rd", rd_b, (rel == 1 || rel == 3) ? 1 : 0);
      if (rel <= 4) chk("b_addr", addr_b, (rel <= 2) ? 27'h40 : 27'h42);
      chk("b_rsp_valid", rsp_valid_b, (rel == 5) ? 1 : 0);
      if (rel == 5) chk("b_rsp_data", rsp_data_b, 32'hAABB_CCDD);
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
